// File: rtl/can_pkg.sv
// Shared types and constants for the CAN frame sequencer: the field
// code seen by the frame consumer, fixed field widths of a standard
// frame, and the data-length helper used when leaving the DLC field.
package can_pkg;

    localparam int ID_BITS  = 11;
    localparam int DLC_BITS = 4;
    localparam int CRC_BITS = 15;

    // Field the sequencer expects the next destuffed bit to belong to.
    typedef enum logic [3:0] {
        IDLE,
        ID,
        RTR,
        IDE,
        R0,
        DLC,
        DATA,
        CRC,
        CRC_DEL,
        ACK,
        ACK_DEL,
        EOF,
        IFS,
        ERROR
    } field_t;

    // Number of data bytes that follow the control field. Remote frames
    // carry no data whatever their DLC; DLC codes above the cap mean
    // "cap bytes".
    function automatic logic [3:0] calc_nbytes(input logic       rtr_bit,
                                               input logic [3:0] dlc_val,
                                               input logic [3:0] max_bytes);
        if (rtr_bit) begin
            return 4'd0;
        end else if (dlc_val > max_bytes) begin
            return max_bytes;
        end else begin
            return dlc_val;
        end
    endfunction

endpackage

// File: rtl/can_field_counter.sv
// Down-counter that tracks the remaining bits of the current frame field.
// The sequencer loads (field length - 1) on every field entry; the count
// then steps once per accepted bit and 'last' marks the field's final bit.
module can_field_counter (
    input  logic       clkin,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       dec,
    output logic       last,
    output logic       byte_last
);

    logic [5:0] count;

    // Remaining-bit count: load wins over decrement, saturates at zero.
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clkin) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 6'd0)) begin
            count <= count - 6'd1;
        end
    end

    assign last = (count == 6'd0);

    // Data fields are loaded with 8*n-1, so the low three bits reach zero
    // exactly on the 8th bit of every byte.
    assign byte_last = (count[2:0] == 3'd0);

endmodule

// File: rtl/can_frame_sequencer.sv
// CAN receive-path frame sequencer for standard (11-bit ID) data and
// remote frames. Follows the destuffed bit stream field by field, keeps
// the unstuffer enabled from SOF through the last CRC bit, captures the
// frame contents and flags form and stuff errors. After an error it waits
// for a run of recessive bits before accepting a new SOF.
module can_frame_sequencer
    import can_pkg::*;
#(
    parameter int EOF_BITS       = 7,
    parameter int IFS_BITS       = 3,
    parameter int IDLE_RECESSIVE = 11,
    parameter int MAX_BYTES      = 8
) (
    input  logic        clkin,
    input  logic        rst,
    input  logic        bit_en,
    input  logic        rxbit,
    input  logic        stuff_err,
    output logic        unstuff_en,
    output field_t      field,
    output logic [10:0] id,
    output logic        rtr,
    output logic [3:0]  dlc,
    output logic [7:0]  data_byte,
    output logic        data_valid,
    output logic [14:0] crc_rx,
    output logic        ack_seen,
    output logic        frame_done,
    output logic        form_err,
    output logic        stuff_fail
);

    field_t      field_nxt;
    logic        unstuff_nxt;
    logic        form_nxt;
    logic        stuff_nxt;
    logic        done_nxt;
    logic        dv_nxt;
    logic        sof;
    logic        stuff_hit;
    logic [3:0]  nbytes_nxt;
    logic [6:0]  len_nxt;
    logic        cnt_load;
    logic [5:0]  cnt_val;
    logic        cnt_last;
    logic        cnt_byte_last;
    logic [7:0]  data_sh;

    // A stuff error only matters while the unstuffer is active; it beats
    // any form check on the same bit.
    assign stuff_hit = bit_en && unstuff_en && stuff_err;

    // Byte count as it will be once the final DLC bit is shifted in; only
    // consumed on the DLC -> DATA/CRC transition, when rtr is already held.
    assign nbytes_nxt = calc_nbytes(rtr, {dlc[2:0], rxbit}, 4'(MAX_BYTES));

    can_field_counter u_counter (
        .clkin     (clkin),
        .rst       (rst),
        .load      (cnt_load),
        .load_val  (cnt_val),
        .dec       (bit_en),
        .last      (cnt_last),
        .byte_last (cnt_byte_last)
    );

    // Next-field decode and one-cycle pulse generation for the accepted bit.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        field_nxt   = field;
        unstuff_nxt = unstuff_en;
        form_nxt    = 1'b0;
        stuff_nxt   = 1'b0;
        done_nxt    = 1'b0;
        dv_nxt      = 1'b0;
        sof         = 1'b0;
        if (stuff_hit) begin
            field_nxt   = ERROR;
            unstuff_nxt = 1'b0;
            stuff_nxt   = 1'b1;
        end else if (bit_en) begin
            unique case (field)
                IDLE: begin
                    if (!rxbit) begin
                        field_nxt   = ID;
                        unstuff_nxt = 1'b1;
                        sof         = 1'b1;
                    end
                end
                ID: begin
                    if (cnt_last) field_nxt = RTR;
                end
                RTR: begin
                    field_nxt = IDE;
                end
                IDE: begin
                    // Extended frames are not supported.
                    if (rxbit) begin
                        field_nxt   = ERROR;
                        unstuff_nxt = 1'b0;
                        form_nxt    = 1'b1;
                    end else begin
                        field_nxt = R0;
                    end
                end
                R0: begin
                    field_nxt = DLC;
                end
                DLC: begin
                    if (cnt_last) field_nxt = (nbytes_nxt == 4'd0) ? CRC : DATA;
                end
                DATA: begin
                    dv_nxt = cnt_byte_last;
                    if (cnt_last) field_nxt = CRC;
                end
                CRC: begin
                    // Delimiter, ACK and EOF are never stuffed.
                    if (cnt_last) begin
                        field_nxt   = CRC_DEL;
                        unstuff_nxt = 1'b0;
                    end
                end
                CRC_DEL: begin
                    if (!rxbit) begin
                        field_nxt = ERROR;
                        form_nxt  = 1'b1;
                    end else begin
                        field_nxt = ACK;
                    end
                end
                ACK: begin
                    field_nxt = ACK_DEL;
                end
                ACK_DEL: begin
                    if (!rxbit) begin
                        field_nxt = ERROR;
                        form_nxt  = 1'b1;
                    end else begin
                        field_nxt = EOF;
                    end
                end
                EOF: begin
                    if (!rxbit) begin
                        field_nxt = ERROR;
                        form_nxt  = 1'b1;
                    end else if (cnt_last) begin
                        field_nxt = IFS;
                        done_nxt  = 1'b1;
                    end
                end
                IFS: begin
                    // A dominant bit here starts the next frame; overload
                    // frames are not recognised.
                    if (!rxbit) begin
                        field_nxt   = ID;
                        unstuff_nxt = 1'b1;
                        sof         = 1'b1;
                    end else if (cnt_last) begin
                        field_nxt = IDLE;
                    end
                end
                ERROR: begin
                    if (rxbit && cnt_last) field_nxt = IDLE;
                end
                default: begin
                    field_nxt   = IDLE;
                    unstuff_nxt = 1'b0;
                end
            endcase
        end
    end

    // Bit length of the field being entered, used to reload the counter.
    always_comb begin
        len_nxt = 7'd1;
        unique case (field_nxt)
            ID:      len_nxt = 7'(ID_BITS);
            DLC:     len_nxt = 7'(DLC_BITS);
            DATA:    len_nxt = {nbytes_nxt, 3'b000};
            CRC:     len_nxt = 7'(CRC_BITS);
            EOF:     len_nxt = 7'(EOF_BITS);
            IFS:     len_nxt = 7'(IFS_BITS);
            ERROR:   len_nxt = 7'(IDLE_RECESSIVE);
            default: len_nxt = 7'd1;
        endcase
    end

    // Reload on every field change; in ERROR a dominant bit restarts the
    // recessive-run count.
    assign cnt_load = bit_en && ((field_nxt != field) || ((field == ERROR) && !rxbit));
    assign cnt_val  = 6'(len_nxt - 7'd1);

    // Field register, unstuffer enable and the single-cycle pulses.
    always_ff @(posedge clkin) begin
        if (rst) begin
            field      <= IDLE;
            unstuff_en <= 1'b0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            form_err   <= 1'b0;
            stuff_fail <= 1'b0;
        end else begin
            field      <= field_nxt;
            unstuff_en <= unstuff_nxt;
            data_valid <= dv_nxt;
            frame_done <= done_nxt;
            form_err   <= form_nxt;
            stuff_fail <= stuff_nxt;
        end
    end

    // Frame content capture: MSB-first shift into the register of the field
    // the accepted bit belongs to. Values persist until overwritten by the
    // next frame, so they remain readable after frame_done.
    always_ff @(posedge clkin) begin
        if (rst) begin
            id        <= '0;
            rtr       <= 1'b0;
            dlc       <= '0;
            data_sh   <= '0;
            data_byte <= '0;
            crc_rx    <= '0;
            ack_seen  <= 1'b0;
        end else if (bit_en && !stuff_hit) begin
            unique case (field)
                ID:   id     <= {id[ID_BITS-2:0], rxbit};
                RTR:  rtr    <= rxbit;
                DLC:  dlc    <= {dlc[DLC_BITS-2:0], rxbit};
                DATA: begin
                    data_sh <= {data_sh[6:0], rxbit};
                    if (cnt_byte_last) data_byte <= {data_sh[6:0], rxbit};
                end
                CRC:  crc_rx <= {crc_rx[CRC_BITS-2:0], rxbit};
                ACK:  ack_seen <= !rxbit;
                default: ;
            endcase
            if (sof) ack_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Self-checking bench for can_frame_sequencer. Frames are described at the
// protocol level (id, rtr, dlc, data, crc, ack) and expanded into a bit
// stream with the field each bit belongs to; expected outputs follow from
// that layout. Bits are applied with random 0..5 cycle gaps between strobes.
module tb_can_frame_sequencer;
    import can_pkg::*;

    localparam int EOF_N  = 7;
    localparam int IFS_N  = 3;
    localparam int IDLE_N = 11;
    localparam int MAXB   = 8;

    typedef struct packed {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [14:0] crc;
        logic        ack;
    } frame_t;

    logic        clkin = 1'b0;
    logic        rst;
    logic        bit_en;
    logic        rxbit;
    logic        stuff_err;
    logic        unstuff_en;
    field_t      field;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [7:0]  data_byte;
    logic        data_valid;
    logic [14:0] crc_rx;
    logic        ack_seen;
    logic        frame_done;
    logic        form_err;
    logic        stuff_fail;

    int vectors     = 0;
    int miscompares = 0;

    // Expected bit stream: bit value, field it belongs to, and what the
    // DUT must report right after accepting it.
    bit         q_bit[$];
    field_t     q_lab[$];
    bit         q_dv[$];
    logic [7:0] q_byte[$];
    bit         q_done[$];
    frame_t     q_frm[$];

    always #5 clkin = ~clkin;

    can_frame_sequencer #(
        .EOF_BITS       (EOF_N),
        .IFS_BITS       (IFS_N),
        .IDLE_RECESSIVE (IDLE_N),
        .MAX_BYTES      (MAXB)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .bit_en     (bit_en),
        .rxbit      (rxbit),
        .stuff_err  (stuff_err),
        .unstuff_en (unstuff_en),
        .field      (field),
        .id         (id),
        .rtr        (rtr),
        .dlc        (dlc),
        .data_byte  (data_byte),
        .data_valid (data_valid),
        .crc_rx     (crc_rx),
        .ack_seen   (ack_seen),
        .frame_done (frame_done),
        .form_err   (form_err),
        .stuff_fail (stuff_fail)
    );

    // Fields whose bits go through the unstuffer.
    function automatic bit in_us(input field_t f);
        return f inside {ID, RTR, IDE, R0, DLC, DATA, CRC};
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        f.id  = 11'($urandom);
        f.rtr = ($urandom_range(0, 3) == 0);
        f.dlc = 4'($urandom);
        f.crc = 15'($urandom);
        f.ack = 1'($urandom);
        return f;
    endfunction

    task automatic push(input bit b, input field_t l, input bit dv, input logic [7:0] by, input bit dn);
        q_bit.push_back(b);
        q_lab.push_back(l);
        q_dv.push_back(dv);
        q_byte.push_back(by);
        q_done.push_back(dn);
    endtask

    task automatic clear_model();
        q_bit.delete();
        q_lab.delete();
        q_dv.delete();
        q_byte.delete();
        q_done.delete();
        q_frm.delete();
    endtask

    // Expand one frame into the expected bit stream.
    task automatic build_frame(input frame_t f, input logic [63:0] dat, input bit use_dat,
                               input field_t sof_lab, input int ifs_ones);
        int         nb;
        logic [7:0] by;
        push(1'b0, sof_lab, 1'b0, 8'h00, 1'b0);
        for (int i = 10; i >= 0; i--) push(f.id[i], ID, 1'b0, 8'h00, 1'b0);
        push(f.rtr, RTR, 1'b0, 8'h00, 1'b0);
        push(1'b0, IDE, 1'b0, 8'h00, 1'b0);
        push(1'($urandom), R0, 1'b0, 8'h00, 1'b0);
        for (int i = 3; i >= 0; i--) push(f.dlc[i], DLC, 1'b0, 8'h00, 1'b0);
        nb = f.rtr ? 0 : ((f.dlc > MAXB) ? MAXB : int'(f.dlc));
        for (int b = 0; b < nb; b++) begin
            by = use_dat ? dat[63-8*b -: 8] : 8'($urandom);
            for (int i = 7; i >= 0; i--) push(by[i], DATA, (i == 0), by, 1'b0);
        end
        for (int i = 14; i >= 0; i--) push(f.crc[i], CRC, 1'b0, 8'h00, 1'b0);
        push(1'b1, CRC_DEL, 1'b0, 8'h00, 1'b0);
        push(!f.ack, ACK, 1'b0, 8'h00, 1'b0);
        push(1'b1, ACK_DEL, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < EOF_N; i++) push(1'b1, EOF, 1'b0, 8'h00, (i == EOF_N - 1));
        for (int i = 0; i < ifs_ones; i++) push(1'b1, IFS, 1'b0, 8'h00, 1'b0);
        q_frm.push_back(f);
    endtask

    // Apply one bit after a random idle gap; during the gap no pulse may fire.
    // Returns at the negedge following the strobed posedge.
    task automatic drive_bit(input bit b, input bit se);
        int gap = $urandom_range(0, 5);
        for (int g = 0; g < gap; g++) begin
            @(negedge clkin);
            rxbit     = 1'($urandom);
            stuff_err = 1'($urandom);
            vectors++;
            if ({data_valid, frame_done, form_err, stuff_fail} !== 4'b0000) begin
                miscompares++;
                $display("FAIL gap_pulse: got dv/done/form/stuff=%b want 0000",
                         {data_valid, frame_done, form_err, stuff_fail});
            end
        end
        bit_en    = 1'b1;
        rxbit     = b;
        stuff_err = se;
        @(negedge clkin);
        bit_en    = 1'b0;
        rxbit     = 1'($urandom);
        stuff_err = 1'($urandom);
    endtask

    // Apply the first n model bits and check the DUT after each.
    task automatic run_bits(input int n, input field_t final_lab);
        field_t     exp_f;
        logic [8:0] exp_v;
        logic [8:0] obs_v;
        frame_t     f;
        bit         se;
        for (int k = 0; k < n; k++) begin
            // stuff_err is noise whenever the unstuffer is off.
            se = in_us(q_lab[k]) ? 1'b0 : 1'($urandom);
            drive_bit(q_bit[k], se);
            exp_f = (k + 1 < q_bit.size()) ? q_lab[k+1] : final_lab;
            exp_v = {exp_f, in_us(exp_f), q_dv[k], q_done[k], 1'b0, 1'b0};
            obs_v = {field, unstuff_en, data_valid, frame_done, form_err, stuff_fail};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL bit_%0d: got field/us/dv/done/form/stuff=%h/%b want %h/%b",
                         k, obs_v[8:5], obs_v[4:0], exp_v[8:5], exp_v[4:0]);
            end
            if (q_dv[k]) begin
                vectors++;
                if (data_byte !== q_byte[k]) begin
                    miscompares++;
                    $display("FAIL data_byte_%0d: got %h want %h", k, data_byte, q_byte[k]);
                end
            end
            if (q_done[k]) begin
                f = q_frm.pop_front();
                vectors++;
                if ({id, rtr, dlc, crc_rx, ack_seen} !== {f.id, f.rtr, f.dlc, f.crc, f.ack}) begin
                    miscompares++;
                    $display("FAIL frame_fields: got id=%h rtr=%b dlc=%h crc=%h ack=%b want id=%h rtr=%b dlc=%h crc=%h ack=%b",
                             id, rtr, dlc, crc_rx, ack_seen, f.id, f.rtr, f.dlc, f.crc, f.ack);
                end
            end
        end
    endtask

    // From ERROR: optional recessive run broken by a dominant bit, then a
    // full IDLE_N recessive run that must return the DUT to IDLE.
    task automatic recover(input int early_ones);
        field_t ef;
        for (int i = 0; i < early_ones; i++) begin
            drive_bit(1'b1, 1'($urandom));
            vectors++;
            if ({field, unstuff_en} !== {ERROR, 1'b0}) begin
                miscompares++;
                $display("FAIL err_early_%0d: got field=%h us=%b want %h/0", i, field, unstuff_en, ERROR);
            end
        end
        if (early_ones > 0) begin
            drive_bit(1'b0, 1'($urandom));
            vectors++;
            if ({field, unstuff_en} !== {ERROR, 1'b0}) begin
                miscompares++;
                $display("FAIL err_sof_ignored: got field=%h us=%b want %h/0", field, unstuff_en, ERROR);
            end
        end
        for (int i = 0; i < IDLE_N; i++) begin
            drive_bit(1'b1, 1'($urandom));
            ef = (i == IDLE_N - 1) ? IDLE : ERROR;
            vectors++;
            if ({field, unstuff_en} !== {ef, 1'b0}) begin
                miscompares++;
                $display("FAIL err_recessive_%0d: got field=%h us=%b want %h/0", i, field, unstuff_en, ef);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bit_en    = 1'b1;
        rxbit     = 1'b0;
        stuff_err = 1'b1;
        repeat (2) @(negedge clkin);
        vectors++;
        if (field !== IDLE || {unstuff_en, id, rtr, dlc, data_byte, data_valid, crc_rx,
                               ack_seen, frame_done, form_err, stuff_fail} !== '0) begin
            miscompares++;
            $display("FAIL reset: got field=%h us=%b id=%h rtr=%b dlc=%h byte=%h crc=%h ack=%b pulses=%b want all zero",
                     field, unstuff_en, id, rtr, dlc, data_byte, crc_rx, ack_seen,
                     {data_valid, frame_done, form_err, stuff_fail});
        end
        rst    = 1'b0;
        bit_en = 1'b0;
    endtask

    task automatic test_basic_frame();
        frame_t f;
        f.id = 11'h123; f.rtr = 1'b0; f.dlc = 4'd2; f.crc = 15'h1ABC; f.ack = 1'b1;
        clear_model();
        build_frame(f, {16'hA55A, 48'h0}, 1'b1, IDLE, IFS_N);
        run_bits(q_bit.size(), IDLE);
    endtask

    task automatic test_rtr_frame();
        frame_t f = rand_frame();
        f.rtr = 1'b1; f.dlc = 4'd4;
        clear_model();
        build_frame(f, 64'h0, 1'b0, IDLE, IFS_N);
        run_bits(q_bit.size(), IDLE);
    endtask

    task automatic test_dlc15();
        frame_t f = rand_frame();
        f.rtr = 1'b0; f.dlc = 4'd15;
        clear_model();
        build_frame(f, 64'h0, 1'b0, IDLE, IFS_N);
        run_bits(q_bit.size(), IDLE);
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 6; n++) begin
            clear_model();
            build_frame(rand_frame(), 64'h0, 1'b0, IDLE, IFS_N);
            run_bits(q_bit.size(), IDLE);
        end
    endtask

    task automatic test_back_to_back();
        clear_model();
        build_frame(rand_frame(), 64'h0, 1'b0, IDLE, $urandom_range(0, IFS_N - 1));
        build_frame(rand_frame(), 64'h0, 1'b0, IFS, IFS_N);
        run_bits(q_bit.size(), IDLE);
    endtask

    task automatic test_stuff_err();
        frame_t f = rand_frame();
        f.rtr = 1'b0; f.dlc = 4'd2;
        clear_model();
        build_frame(f, 64'h0, 1'b0, IDLE, IFS_N);
        // SOF + ID + RTR + IDE + R0 + DLC = 19 bits, so the 3rd DATA bit is index 21.
        run_bits(21, IDLE);
        drive_bit(q_bit[21], 1'b1);
        vectors++;
        if ({field, unstuff_en, data_valid, frame_done, form_err, stuff_fail} !== {ERROR, 5'b00001}) begin
            miscompares++;
            $display("FAIL stuff_err: got field=%h us/dv/done/form/stuff=%b want %h/00001",
                     field, {unstuff_en, data_valid, frame_done, form_err, stuff_fail}, ERROR);
        end
        clear_model();
        recover(5);
        build_frame(rand_frame(), 64'h0, 1'b0, IDLE, IFS_N);
        run_bits(q_bit.size(), IDLE);
    endtask

    task automatic test_eof_err();
        int eof_start;
        clear_model();
        build_frame(rand_frame(), 64'h0, 1'b0, IDLE, IFS_N);
        eof_start = q_bit.size() - IFS_N - EOF_N;
        run_bits(eof_start + 2, IDLE);
        drive_bit(1'b0, 1'($urandom));
        vectors++;
        if ({field, unstuff_en, data_valid, frame_done, form_err, stuff_fail} !== {ERROR, 5'b00010}) begin
            miscompares++;
            $display("FAIL eof_form: got field=%h us/dv/done/form/stuff=%b want %h/00010",
                     field, {unstuff_en, data_valid, frame_done, form_err, stuff_fail}, ERROR);
        end
        clear_model();
        recover(0);
    endtask

    task automatic test_ide_err();
        clear_model();
        build_frame(rand_frame(), 64'h0, 1'b0, IDLE, IFS_N);
        run_bits(13, IDLE);
        drive_bit(1'b1, 1'b0);
        vectors++;
        if ({field, unstuff_en, data_valid, frame_done, form_err, stuff_fail} !== {ERROR, 5'b00010}) begin
            miscompares++;
            $display("FAIL ide_form: got field=%h us/dv/done/form/stuff=%b want %h/00010",
                     field, {unstuff_en, data_valid, frame_done, form_err, stuff_fail}, ERROR);
        end
        clear_model();
        recover($urandom_range(1, 4));
    endtask

    task automatic test_rst_mid_frame();
        frame_t f = rand_frame();
        f.rtr = 1'b0; f.dlc = 4'd3;
        clear_model();
        build_frame(f, 64'h0, 1'b0, IDLE, IFS_N);
        run_bits(19 + $urandom_range(1, 20), IDLE);
        rst       = 1'b1;
        bit_en    = 1'b1;
        rxbit     = 1'b0;
        stuff_err = 1'b1;
        @(negedge clkin);
        vectors++;
        if (field !== IDLE || {unstuff_en, id, rtr, dlc, data_byte, data_valid, crc_rx,
                               ack_seen, frame_done, form_err, stuff_fail} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_frame: got field=%h us=%b id=%h dlc=%h byte=%h crc=%h pulses=%b want all zero",
                     field, unstuff_en, id, dlc, data_byte, crc_rx,
                     {data_valid, frame_done, form_err, stuff_fail});
        end
        rst    = 1'b0;
        bit_en = 1'b0;
        clear_model();
        build_frame(rand_frame(), 64'h0, 1'b0, IDLE, IFS_N);
        run_bits(q_bit.size(), IDLE);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_rtr_frame();
        test_dlc15();
        test_random_frames();
        test_back_to_back();
        test_stuff_err();
        test_eof_err();
        test_ide_err();
        test_rst_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
